// File: rtl/id_ctrl_stage.sv
// Decode-stage controller: decodes RV32I(+M) into the datapath control bundle
// and registers it into the ID/EX slot with load-use stall, flush and trap.
module id_ctrl_stage #(
  parameter int XLEN         = 32,
  parameter bit ENABLE_M     = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            ex_ready,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [14:0]     out_ctrl,
  output logic            trap
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic {RUN, TRAP} state_t;

  state_t          r_state;
  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [14:0]     r_ctrl;

  logic [14:0] w_dec;
  logic [14:0] w_ctrl;
  logic        w_illegal;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic [6:0]  w_funct7;
  logic [4:0]  w_out_rd;
  logic        w_haz;
  logic        w_ready;
  logic        w_accept;

  assign w_funct7 = in_instr[31:25];

  // Bundle: [1:0] ResultSrc [2] MemWrite [3] Branch [4] ALUSrc [6:5] ALUSrcA
  // [7] RegWrite [8] Jump [11:9] ImmSrc [13:12] ALUOp [14] illegal
  always_comb begin
    w_dec     = '0;
    w_illegal = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (in_instr[6:0])
      OPC_OP: begin
        w_dec[7]     = 1'b1;
        w_dec[13:12] = 2'b10;
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        if (ENABLE_M && w_funct7 == 7'b0000001)
          w_dec[13:12] = 2'b11;
        else if (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)
          w_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        w_dec[7]     = 1'b1;
        w_dec[4]     = 1'b1;
        w_dec[13:12] = 2'b10;
        w_use_rs1    = 1'b1;
      end
      OPC_LOAD: begin
        w_dec[7]   = 1'b1;
        w_dec[4]   = 1'b1;
        w_dec[1:0] = 2'b01;
        w_use_rs1  = 1'b1;
      end
      OPC_STORE: begin
        w_dec[2]    = 1'b1;
        w_dec[4]    = 1'b1;
        w_dec[11:9] = 3'b001;
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec[3]     = 1'b1;
        w_dec[11:9]  = 3'b010;
        w_dec[13:12] = 2'b01;
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
      end
      OPC_JAL: begin
        w_dec[7]    = 1'b1;
        w_dec[8]    = 1'b1;
        w_dec[11:9] = 3'b011;
        w_dec[1:0]  = 2'b10;
      end
      OPC_JALR: begin
        w_dec[7]   = 1'b1;
        w_dec[8]   = 1'b1;
        w_dec[4]   = 1'b1;
        w_dec[1:0] = 2'b10;
        w_use_rs1  = 1'b1;
      end
      OPC_LUI: begin
        w_dec[7]    = 1'b1;
        w_dec[4]    = 1'b1;
        w_dec[6:5]  = 2'b10;
        w_dec[11:9] = 3'b100;
      end
      OPC_AUIPC: begin
        w_dec[7]    = 1'b1;
        w_dec[4]    = 1'b1;
        w_dec[6:5]  = 2'b01;
        w_dec[11:9] = 3'b100;
      end
      default: w_illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11)
      w_illegal = 1'b1;
    w_ctrl = w_illegal ? 15'h4000 : w_dec;
  end

  // Load-use: the load in the slot writes a register the incoming op reads.
  assign w_out_rd = r_instr[11:7];
  assign w_haz = r_valid && (r_ctrl[1:0] == 2'b01) && r_ctrl[7] && (w_out_rd != 5'd0) &&
                 ((w_use_rs1 && w_out_rd == in_instr[19:15]) ||
                  (w_use_rs2 && w_out_rd == in_instr[24:20]));

  assign w_ready  = (r_state == RUN) && !flush && !w_haz && (!r_valid || ex_ready);
  assign w_accept = in_valid && w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_state <= RUN;
    end else if (w_accept) begin
      r_instr <= in_instr;
      r_pc    <= in_pc;
      r_ctrl  <= w_ctrl;
      r_valid <= !(w_illegal && !ILLEGAL_TRAP);
      if (w_illegal && ILLEGAL_TRAP)
        r_state <= TRAP;
    end else if (ex_ready && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_pc    = r_pc;
  assign out_ctrl  = r_ctrl;
  assign trap      = (r_state == TRAP);

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: three parameter configurations share one stimulus
// stream and are each compared against a table-driven reference model.
module tb_id_ctrl_stage;

  localparam logic [31:0] I_ADD  = 32'h00228333;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_MUL  = 32'h022083B3;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_ADDI = 32'h00100093;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, ex_ready;
  logic [31:0] in_instr, in_pc;

  logic        rdy [3];
  logic        ov  [3];
  logic [31:0] oi  [3];
  logic [31:0] op  [3];
  logic [14:0] oc  [3];
  logic        tr  [3];

  // Config 0: M on, trap on. Config 1: M off, trap on. Config 2: M on, trap off.
  bit en_m   [3] = '{1'b1, 1'b0, 1'b1};
  bit trap_en[3] = '{1'b1, 1'b1, 1'b0};

  id_ctrl_stage #(.XLEN(32), .ENABLE_M(1'b1), .ILLEGAL_TRAP(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_instr(in_instr), .in_pc(in_pc), .ex_ready(ex_ready), .out_valid(ov[0]),
    .out_instr(oi[0]), .out_pc(op[0]), .out_ctrl(oc[0]), .trap(tr[0]));
  id_ctrl_stage #(.XLEN(32), .ENABLE_M(1'b0), .ILLEGAL_TRAP(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_instr(in_instr), .in_pc(in_pc), .ex_ready(ex_ready), .out_valid(ov[1]),
    .out_instr(oi[1]), .out_pc(op[1]), .out_ctrl(oc[1]), .trap(tr[1]));
  id_ctrl_stage #(.XLEN(32), .ENABLE_M(1'b1), .ILLEGAL_TRAP(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_instr(in_instr), .in_pc(in_pc), .ex_ready(ex_ready), .out_valid(ov[2]),
    .out_instr(oi[2]), .out_pc(op[2]), .out_ctrl(oc[2]), .trap(tr[2]));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit          known = 1'b0;
  bit          mv [3];
  logic [31:0] mi [3];
  logic [31:0] mp [3];
  logic [14:0] mc [3];
  bit          mt [3];
  logic        last_rdy [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control word per instruction class, straight from the decode table.
  function automatic logic [14:0] ref_ctrl(input logic [31:0] ins, input bit m);
    logic [6:0] f7;
    f7 = ins[31:25];
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) return 15'h2080;
        if (f7 == 7'h01 && m)           return 15'h3080;
        return 15'h4000;
      end
      7'h13:   return 15'h2090;
      7'h03:   return 15'h0091;
      7'h23:   return 15'h0214;
      7'h63:   return 15'h1408;
      7'h6F:   return 15'h0782;
      7'h67:   return 15'h0192;
      7'h37:   return 15'h08D0;
      7'h17:   return 15'h08B0;
      default: return 15'h4000;
    endcase
  endfunction

  function automatic bit ref_ready(input int k, input logic [31:0] ins, input bit fl, input bit er);
    logic [6:0] opc;
    logic [4:0] rd;
    bit u1, u2, haz;
    opc = ins[6:0];
    rd  = mi[k][11:7];
    u1  = (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23 ||
           opc == 7'h63 || opc == 7'h67);
    u2  = (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
    haz = mv[k] && mc[k] == 15'h0091 && rd != 5'd0 &&
          ((u1 && rd == ins[19:15]) || (u2 && rd == ins[24:20]));
    return !mt[k] && !fl && !haz && (!mv[k] || er);
  endfunction

  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit er, input bit fl, input bit rn);
    bit          r [3];
    logic [14:0] c;
    rst_n = rn; flush = fl; in_valid = v; in_instr = ins; in_pc = pc; ex_ready = er;
    #1;
    for (int k = 0; k < 3; k++) begin
      last_rdy[k] = rdy[k];
      r[k] = known && ref_ready(k, ins, fl, er);
      if (known) chk($sformatf("u%0d.in_ready", k), {31'd0, rdy[k]}, {31'd0, r[k]});
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      c = ref_ctrl(ins, en_m[k]);
      if (!rn) begin
        mv[k] = 0; mi[k] = '0; mp[k] = '0; mc[k] = '0; mt[k] = 0;
      end else if (fl) begin
        mv[k] = 0; mt[k] = 0;
      end else if (v && r[k]) begin
        mi[k] = ins; mp[k] = pc; mc[k] = c;
        mv[k] = !(c[14] && !trap_en[k]);
        if (c[14] && trap_en[k]) mt[k] = 1;
      end else if (er && mv[k]) begin
        mv[k] = 0;
      end
    end
    if (!rn) known = 1'b1;
    #1;
    if (known) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d.out_valid", k), {31'd0, ov[k]}, {31'd0, mv[k]});
        chk($sformatf("u%0d.out_instr", k), oi[k], mi[k]);
        chk($sformatf("u%0d.out_pc", k), op[k], mp[k]);
        chk($sformatf("u%0d.out_ctrl", k), {17'd0, oc[k]}, {17'd0, mc[k]});
        chk($sformatf("u%0d.trap", k), {31'd0, tr[k]}, {31'd0, mt[k]});
      end
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [11];
    logic [6:0] f7s [4];
    logic [31:0] w;
    ops = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h05};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    w[31:25] = f7s[$urandom_range(0, 3)];
    return w;
  endfunction

  initial begin
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    chk("reset.ctrl", {17'd0, oc[0]}, 32'h0);
    chk("reset.valid", {31'd0, ov[0]}, 32'h0);

    cycle(1, I_ADD, 32'h100, 1, 0, 1);
    chk("add.valid", {31'd0, ov[0]}, 32'h1);
    chk("add.ctrl", {17'd0, oc[0]}, 32'h2080);
    chk("add.pc", op[0], 32'h100);

    cycle(1, I_LW, 32'h104, 1, 0, 1);
    chk("lw.ctrl", {17'd0, oc[0]}, 32'h091);
    cycle(1, I_ADD, 32'h108, 1, 0, 1);
    chk("loaduse.stall", {31'd0, last_rdy[0]}, 32'h0);
    chk("loaduse.bubble", {31'd0, ov[0]}, 32'h0);
    cycle(1, I_ADD, 32'h108, 1, 0, 1);
    chk("loaduse.resume", {31'd0, last_rdy[0]}, 32'h1);
    chk("loaduse.add", {17'd0, oc[0]}, 32'h2080);

    cycle(1, I_MUL, 32'h10C, 1, 0, 1);
    chk("mul.m1", {17'd0, oc[0]}, 32'h3080);
    chk("mul.m0.ctrl", {17'd0, oc[1]}, 32'h4000);
    chk("mul.m0.trap", {31'd0, tr[1]}, 32'h1);
    cycle(1, I_ADD, 32'h110, 1, 0, 1);
    chk("trap.hold_ready", {31'd0, last_rdy[1]}, 32'h0);
    chk("trap.slot_kept", {31'd0, ov[1]}, 32'h0);
    cycle(0, '0, '0, 1, 1, 1);
    chk("flush.trap", {31'd0, tr[1]}, 32'h0);
    cycle(0, '0, '0, 1, 0, 1);
    chk("flush.ready", {31'd0, last_rdy[1]}, 32'h1);

    cycle(1, I_LUI, 32'h200, 1, 0, 1);
    chk("lui.ctrl", {17'd0, oc[0]}, 32'h8D0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, I_ADDI, 32'h204, 0, 0, 1);
      chk("lui.stable", {17'd0, oc[0]}, 32'h8D0);
      chk("lui.blocked", {31'd0, last_rdy[0]}, 32'h0);
    end
    cycle(1, I_ADDI, 32'h204, 1, 0, 1);
    chk("lui.release", {31'd0, last_rdy[0]}, 32'h1);
    chk("lui.next_pc", op[0], 32'h204);

    cycle(1, 32'hFFFFFFFF, 32'h300, 1, 0, 1);
    chk("ill.valid", {31'd0, ov[2]}, 32'h0);
    chk("ill.bit14", {31'd0, oc[2][14]}, 32'h1);
    chk("ill.notrap", {31'd0, tr[2]}, 32'h0);
    chk("ill.trap_cfg", {31'd0, tr[0]}, 32'h1);
    cycle(1, I_ADD, 32'h304, 1, 0, 1);
    chk("ill.next_ready", {31'd0, last_rdy[2]}, 32'h1);
    chk("ill.next_ctrl", {17'd0, oc[2]}, 32'h2080);
    cycle(0, '0, '0, 1, 1, 1);

    cycle(1, I_ADD, 32'h400, 0, 0, 1);
    cycle(0, '0, '0, 0, 1, 0);
    chk("rstflush.valid", {31'd0, ov[0]}, 32'h0);
    chk("rstflush.instr", oi[0], 32'h0);
    chk("rstflush.pc", op[0], 32'h0);
    chk("rstflush.ctrl", {17'd0, oc[0]}, 32'h0);
    cycle(1, I_ADD, 32'h500, 1, 1, 1);
    chk("flush.noaccept", {31'd0, ov[0]}, 32'h0);
    chk("flush.pc", op[0], 32'h0);

    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 99) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ctrl_stage.md
Name: id_ctrl_stage

Overview:
- Parametrised decode-stage controller for the pipelined RV32I core.
- Decodes each instruction into the datapath control bundle and registers it into the ID/EX slot under a valid/ready handshake.
- Adds capabilities the single-cycle main decoder lacks: load-use bubble insertion, flush, optional M-extension decode, illegal-instruction detection with a sticky trap state, and separated U/J immediate types.
- Sits between the fetch buffer (upstream) and the execute stage (downstream).

Parameters:
- XLEN, 32: PC width.
- ENABLE_M, 1: 1 = decode OP with funct7=0000001 as mul/div (ALUOp=11); 0 = that encoding is illegal.
- ILLEGAL_TRAP, 1: 1 = an illegal instruction enters TRAP; 0 = it is passed downstream as a bubble with the illegal bit set and out_valid=0.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: synchronous active-low reset.
- flush, input, 1: sync kill of the held slot; clears TRAP.
- in_valid, input, 1: upstream instruction valid.
- in_ready, output, 1: stage accepts in_instr/in_pc this cycle.
- in_instr, input, 32: instruction word.
- in_pc, input, XLEN: instruction PC.
- ex_ready, input, 1: execute stage consumes out slot this cycle.
- out_valid, output, 1: out slot holds a real instruction.
- out_instr, output, 32: registered instruction (EX extracts rd/rs/funct).
- out_pc, output, XLEN: registered PC.
- out_ctrl, output, 15: registered control bundle, laid out as:
  - [1:0] ResultSrc: 00 ALU, 01 mem, 10 PC+4.
  - [2] MemWrite.
  - [3] Branch.
  - [4] ALUSrc.
  - [6:5] ALUSrcA: 00 rs1, 01 PC, 10 zero.
  - [7] RegWrite.
  - [8] Jump.
  - [11:9] ImmSrc: 000 I, 001 S, 010 B, 011 J, 100 U.
  - [13:12] ALUOp: 00 add, 01 branch, 10 funct, 11 muldiv.
  - [14] illegal.
- trap, output, 1: high while the stage is in TRAP.

Behaviour:
- Reset (rst_n=0 at posedge):
  - out_valid=0, out_instr=0, out_pc=0, out_ctrl=0, trap=0, state=RUN.
  - Reset has priority over flush.
- Decode (combinational, from in_instr):
  - OP: RegWrite, ALUOp=10.
  - OP_IMM: RegWrite, ALUSrc, ALUOp=10.
  - LOAD: RegWrite, ALUSrc, ResultSrc=01.
  - STORE: MemWrite, ALUSrc, ImmSrc=001.
  - BRANCH: Branch, ImmSrc=010, ALUOp=01.
  - JAL: RegWrite, Jump, ImmSrc=011, ResultSrc=10.
  - JALR: RegWrite, Jump, ALUSrc, ResultSrc=10.
  - LUI: RegWrite, ALUSrc, ALUSrcA=10, ImmSrc=100.
  - AUIPC: RegWrite, ALUSrc, ALUSrcA=01, ImmSrc=100.
  - Unlisted fields are 0.
- Illegal when any of:
  - in_instr[1:0]!=11;
  - the opcode is not in the list above;
  - OP with funct7 not 0000000/0100000 (also accepting 0000001 when ENABLE_M=1).
  - An illegal instruction decodes with ctrl=0 except bit14.
- Source use:
  - rs1 is used by OP, OP_IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
- Load-use hazard (haz) requires all of:
  - out_valid=1, ResultSrc=01, RegWrite=1;
  - out rd != 0;
  - out rd equals a used rs1 or rs2 of in_instr.
- in_ready = state==RUN && !flush && !haz && (!out_valid || ex_ready).
- Slot update per posedge, in priority order:
  1. flush → out_valid=0, state=RUN; the input is not accepted that cycle.
  2. in_valid && in_ready → load decoded ctrl/instr/pc.
     - out_valid=1, unless illegal with ILLEGAL_TRAP=0, in which case out_valid=0 and ctrl[14]=1.
     - If illegal and ILLEGAL_TRAP=1, also state=TRAP.
  3. ex_ready && out_valid (no accept) → out_valid=0 (bubble).
  4. Otherwise hold all outputs.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction/cycle when ex_ready=1 and there is no hazard.
- A load-use hazard costs exactly one bubble cycle.
- States: RUN, TRAP.
  - TRAP holds in_ready=0 and trap=1.
  - In TRAP the illegal instruction stays in the out slot (out_valid=1, ctrl[14]=1) until consumed; later slots are bubbles.
  - TRAP exits only via flush or reset.
- Flush in the same cycle as ex_ready: the slot is killed; consumption by EX is irrelevant.
- Held outputs are stable while out_valid && !ex_ready (no combinational change).

Test Plan:
- Reset with rst_n=0 for 2 cycles, then in_valid=1, in_instr=0x00228333 (add), ex_ready=1 → next cycle out_valid=1, out_ctrl=0x2080, out_pc=in_pc.
- Send 0x0000A283 (lw x5) then 0x00228333 (add x6,x5,x2) with ex_ready=1:
  - in_ready=0 for exactly one cycle;
  - then one cycle with out_valid=0;
  - then add appears with ctrl=0x2080.
  - lw ctrl must be 0x091.
- Send 0x022083B3 (mul):
  - ENABLE_M=1 → ctrl=0x3080;
  - ENABLE_M=0, ILLEGAL_TRAP=1 → ctrl=0x4000, trap=1, in_ready stays 0;
  - flush → trap=0, in_ready=1 next cycle.
- Send 0x123450B7 (lui) with ex_ready=0 for 3 cycles:
  - out_ctrl=0x8D0 is held stable;
  - in_ready=0;
  - the second instruction is accepted in the cycle ex_ready returns to 1.
- Send 0xFFFFFFFF with ILLEGAL_TRAP=0 → out_valid=0, ctrl[14]=1, trap=0, and the next instruction is accepted normally.
- Assert flush and rst_n=0 in the same cycle while the slot is full → all outputs 0; assert flush alone with in_valid=1 → input not accepted, out_valid=0.
